// File: rtl/vx_operands_mseq_arb_pkg.sv
// Shared types for the operand-collector arbiter.
//   operands_t   : one operand-collector beat, forwarded unmodified
//   mseq_state_e : arbiter FSM state
//   M_TYPE_NONE  : m_type value marking a scalar (non-matrix) op
//   MSEQ_CNT_W   : width of matrix group counters (groups of up to 15 beats)
package vx_operands_mseq_arb_pkg;

  localparam int MSEQ_CNT_W = 4;
  localparam int M_TYPE_W   = 2;

  localparam logic [M_TYPE_W-1:0] M_TYPE_NONE = '0;

  typedef struct packed {
    logic [1:0]            wid;
    logic [3:0]            tmask;
    logic [31:0]           pc;
    logic [3:0]            op_type;
    logic [4:0]            rd;
    logic [31:0]           rs1_data;
    logic [31:0]           rs2_data;
    logic [31:0]           rs3_data;
    logic [M_TYPE_W-1:0]   m_type;
    logic [3:0]            m_instr_id;
    logic [MSEQ_CNT_W-1:0] m_instr_cnt;
    logic [3:0]            m_row_size;
  } operands_t;

  typedef enum logic {
    MSEQ_IDLE   = 1'b0,
    MSEQ_LOCKED = 1'b1
  } mseq_state_e;

  // A matrix op opens a locked group only when it spans more than one beat;
  // counts of 0 and 1 are treated as single-beat ops.
  function automatic logic mseq_starts(input operands_t d);
    return (d.m_type != M_TYPE_NONE) && (d.m_instr_cnt > MSEQ_CNT_W'(1));
  endfunction

  function automatic logic mseq_beat_bad(input operands_t d, input logic [3:0] grp_id);
    return (d.m_instr_id != grp_id) || (d.m_type == M_TYPE_NONE);
  endfunction

endpackage

// File: rtl/vx_operands_mseq_arb_rr_grant.sv
// Round-robin picker: grants the first asserted request at or after ptr,
// wrapping modulo NUM_REQS.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant_oh  : one-hot grant
//   grant_idx : index of the granted request
//   grant_vld : some request was granted
module vx_rr_grant #(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [NUM_REQS-1:0] grant_oh,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_vld
);

  int               sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = 0;
    cand      = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQS) sum = sum - NUM_REQS;
      cand = IDX_W'(sum);
      if (!grant_vld && req[cand]) begin
        grant_vld      = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/vx_operands_mseq_arb.sv
// Shares one operand-collector output among NUM_REQS issue slices. Scalar
// ops are granted round-robin; a multi-beat matrix group locks the grant to
// its requester until all beats are through. Optional registered output.
//   clk, reset               : clock, async active-low reset
//   operands_in_valid/data   : per-requester beat offer
//   operands_in_ready        : per-requester accept
//   operands_out_valid/data  : dispatch beat
//   operands_out_ready       : dispatch accept
//   locked, lock_owner       : matrix group in progress and its owner
//   seq_err                  : sticky matrix-sequence protocol error
//
// state       | meaning
// MSEQ_IDLE   | round-robin among all valid requesters
// MSEQ_LOCKED | only lock_owner eligible until grp_cnt beats transferred
module vx_operands_mseq_arb
  import vx_operands_mseq_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int OUT_BUF  = 1,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] operands_in_valid,
  input  operands_t           operands_in_data [NUM_REQS],
  output logic [NUM_REQS-1:0] operands_in_ready,
  output logic                operands_out_valid,
  output operands_t           operands_out_data,
  input  logic                operands_out_ready,
  output logic                locked,
  output logic [IDX_W-1:0]    lock_owner,
  output logic                seq_err
);

  mseq_state_e           state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      lock_owner_q, lock_owner_d;
  logic [3:0]            grp_id_q, grp_id_d;
  logic [MSEQ_CNT_W-1:0] grp_cnt_q, grp_cnt_d;
  logic [MSEQ_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  seq_err_q, seq_err_d;
  logic                  out_valid_q, out_valid_d;
  operands_t             out_data_q, out_data_d;

  logic [NUM_REQS-1:0] owner_oh, elig_req, gnt_oh;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_vld, fwd_ok, accept;
  operands_t           acc_data;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQS - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  always_comb begin
    owner_oh               = '0;
    owner_oh[lock_owner_q] = 1'b1;
    elig_req = (state_q == MSEQ_LOCKED) ? (operands_in_valid & owner_oh) : operands_in_valid;
  end

  vx_rr_grant #(.NUM_REQS(NUM_REQS), .IDX_W(IDX_W)) u_rr_grant (
    .req       (elig_req),
    .ptr       (rr_ptr_q),
    .grant_oh  (gnt_oh),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  // With the buffer, a full slot still accepts when it drains this cycle.
  always_comb begin
    fwd_ok            = (OUT_BUF != 0) ? (!out_valid_q || operands_out_ready) : operands_out_ready;
    accept            = gnt_vld && fwd_ok;
    operands_in_ready = fwd_ok ? gnt_oh : '0;
    acc_data          = operands_in_data[gnt_idx];
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    grp_id_d     = grp_id_q;
    grp_cnt_d    = grp_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    seq_err_d    = seq_err_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (operands_out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data;
    end

    if (accept) begin
      case (state_q)
        MSEQ_IDLE: begin
          rr_ptr_d = next_idx(gnt_idx);
          if (mseq_starts(acc_data)) begin
            state_d      = MSEQ_LOCKED;
            lock_owner_d = gnt_idx;
            grp_id_d     = acc_data.m_instr_id;
            grp_cnt_d    = acc_data.m_instr_cnt;
            beat_cnt_d   = MSEQ_CNT_W'(1);
          end
        end
        MSEQ_LOCKED: begin
          // A bad beat is still forwarded and counted so the group always closes.
          if (mseq_beat_bad(acc_data, grp_id_q)) seq_err_d = 1'b1;
          if (beat_cnt_q == grp_cnt_q - MSEQ_CNT_W'(1)) begin
            state_d    = MSEQ_IDLE;
            rr_ptr_d   = next_idx(lock_owner_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + MSEQ_CNT_W'(1);
          end
        end
        default: state_d = MSEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= MSEQ_IDLE;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      grp_id_q     <= '0;
      grp_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      seq_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      grp_id_q     <= grp_id_d;
      grp_cnt_q    <= grp_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      seq_err_q    <= seq_err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  always_comb begin
    operands_out_valid = (OUT_BUF != 0) ? out_valid_q : gnt_vld;
    operands_out_data  = (OUT_BUF != 0) ? out_data_q : acc_data;
    locked             = (state_q == MSEQ_LOCKED);
    lock_owner         = lock_owner_q;
    seq_err            = seq_err_q;
  end

endmodule

// File: tb/tb_vx_operands_mseq_arb.sv
// Bench for vx_operands_mseq_arb (NUM_REQS=4, OUT_BUF=1). Per-requester
// source queues drive the inputs; accepted beats go to a scoreboard queue
// and are compared in order against the dispatch output.
module tb_vx_operands_mseq_arb;
  import vx_operands_mseq_arb_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] in_valid, in_ready;
  operands_t    in_data [N];
  logic         out_valid, out_ready;
  operands_t    out_data;
  logic         locked, seq_err;
  logic [1:0]   lock_owner;

  always #5 clk = ~clk;

  vx_operands_mseq_arb #(.NUM_REQS(N), .OUT_BUF(1)) dut (
    .clk                (clk),
    .reset              (reset),
    .operands_in_valid  (in_valid),
    .operands_in_data   (in_data),
    .operands_in_ready  (in_ready),
    .operands_out_valid (out_valid),
    .operands_out_data  (out_data),
    .operands_out_ready (out_ready),
    .locked             (locked),
    .lock_owner         (lock_owner),
    .seq_err            (seq_err)
  );

  int        errors = 0;
  int        checks = 0;
  int        serial = 0;
  int        n_out  = 0;
  bit        rand_rdy = 1'b0;
  operands_t src_q [N][$];
  operands_t exp_q [$];
  logic [N-1:0] en = '1;
  logic [N-1:0] acc_flag = '0;
  logic      prev_stall = 1'b0;
  operands_t prev_data;
  operands_t mon_e;

  typedef struct {
    logic [3:0] rdy;
    logic       ovalid;
  } vec_t;
  vec_t t1 [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: outputs popped before this edge's accepts are pushed.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      acc_flag   = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got data=%h expected no beat", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e) begin
            errors++;
            $display("FAIL out_data: got %h expected %h", out_data, mon_e);
          end
        end
      end
      for (int g = 0; g < N; g++) begin
        acc_flag[g] = in_valid[g] && in_ready[g];
        if (acc_flag[g]) exp_q.push_back(in_data[g]);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic drive();
    for (int g = 0; g < N; g++) begin
      in_valid[g] = en[g] && (src_q[g].size() > 0);
      in_data[g]  = (src_q[g].size() > 0) ? src_q[g][0] : '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < N; g++)
      if (acc_flag[g] && src_q[g].size() > 0) src_q[g].delete(0);
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic load(input int g, input logic [1:0] mt, input logic [3:0] id, input logic [3:0] cnt);
    operands_t b;
    serial++;
    b            = '0;
    b.wid        = 2'(g);
    b.tmask      = 4'hF;
    b.pc         = 32'h1000 + 32'(serial * 4);
    b.op_type    = 4'(serial);
    b.rd         = 5'(serial);
    b.rs1_data   = {8'hA0, 8'(g), 16'(serial)};
    b.rs2_data   = $urandom;
    b.rs3_data   = ~b.rs1_data;
    b.m_type     = mt;
    b.m_instr_id = id;
    b.m_instr_cnt = cnt;
    b.m_row_size = 4'(serial);
    src_q[g].push_back(b);
    drive();
  endtask

  task automatic cyc(input string tag, input logic [3:0] rdy, input logic lk,
                     input logic [1:0] own, input logic serr);
    @(negedge clk);
    chk({tag, " ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, " locked"}, 32'(locked), 32'(lk));
    if (lk) chk({tag, " owner"}, 32'(lock_owner), 32'(own));
    chk({tag, " seq_err"}, 32'(seq_err), 32'(serr));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0;
    bit  done;

    t1[0] = '{4'b0001, 1'b0};
    t1[1] = '{4'b0010, 1'b1};
    t1[2] = '{4'b0100, 1'b1};
    t1[3] = '{4'b1000, 1'b1};
    t1[4] = '{4'b0001, 1'b1};
    t1[5] = '{4'b0010, 1'b1};
    t1[6] = '{4'b0100, 1'b1};
    t1[7] = '{4'b1000, 1'b1};
    t1[8] = '{4'b0000, 1'b1};
    t1[9] = '{4'b0000, 1'b0};

    reset     = 1'b0;
    out_ready = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst locked", 32'(locked), 0);
    chk("rst owner", 32'(lock_owner), 0);
    chk("rst seq_err", 32'(seq_err), 0);
    chk("rst out_data", out_data.rs1_data | out_data.pc | 32'(out_data.m_instr_cnt), 0);

    // Test 1: all scalar, round robin; single-beat matrix ops do not lock.
    @(posedge clk);
    #1 reset = 1'b1;
    for (int g = 0; g < N; g++) begin
      if (g == 2)      load(g, 2'd1, 4'd1, 4'd1);
      else if (g == 3) load(g, 2'd1, 4'd2, 4'd0);
      else             load(g, 2'd0, 4'd0, 4'd0);
      load(g, 2'd0, 4'd0, 4'd0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t1[%0d] ready", i), 32'(in_ready), 32'(t1[i].rdy));
      chk($sformatf("t1[%0d] out_valid", i), 32'(out_valid), 32'(t1[i].ovalid));
      chk($sformatf("t1[%0d] locked", i), 32'(locked), 0);
      tick();
    end

    // Test 2: 4-beat group on req1 with req0/req2 competing.
    load(0, 2'd0, 4'd0, 4'd0);
    cyc("t2 pre", 4'b0001, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) load(1, 2'd1, 4'd5, 4'd4);
    load(0, 2'd0, 4'd0, 4'd0);
    load(2, 2'd0, 4'd0, 4'd0);
    cyc("t2 b0", 4'b0010, 1'b0, 2'd0, 1'b0);
    cyc("t2 b1", 4'b0010, 1'b1, 2'd1, 1'b0);
    cyc("t2 b2", 4'b0010, 1'b1, 2'd1, 1'b0);
    cyc("t2 b3", 4'b0010, 1'b1, 2'd1, 1'b0);
    cyc("t2 next", 4'b0100, 1'b0, 2'd0, 1'b0);
    cyc("t2 r0", 4'b0001, 1'b0, 2'd0, 1'b0);
    cyc("t2 idle", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Test 3: owner drops valid for 3 cycles mid-group.
    for (int k = 0; k < 4; k++) load(1, 2'd1, 4'd7, 4'd4);
    load(0, 2'd0, 4'd0, 4'd0);
    load(3, 2'd0, 4'd0, 4'd0);
    cyc("t3 b0", 4'b0010, 1'b0, 2'd0, 1'b0);
    cyc("t3 b1", 4'b0010, 1'b1, 2'd1, 1'b0);
    en[1] = 1'b0;
    drive();
    for (int k = 0; k < 3; k++) cyc("t3 stall", 4'b0000, 1'b1, 2'd1, 1'b0);
    en[1] = 1'b1;
    drive();
    cyc("t3 b2", 4'b0010, 1'b1, 2'd1, 1'b0);
    cyc("t3 b3", 4'b0010, 1'b1, 2'd1, 1'b0);
    cyc("t3 next", 4'b1000, 1'b0, 2'd0, 1'b0);
    cyc("t3 r0", 4'b0001, 1'b0, 2'd0, 1'b0);
    cyc("t3 idle", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Test 4: wrong m_instr_id inside a 3-beat group.
    load(1, 2'd1, 4'd5, 4'd3);
    load(1, 2'd1, 4'd6, 4'd3);
    load(1, 2'd1, 4'd5, 4'd3);
    load(2, 2'd0, 4'd0, 4'd0);
    cyc("t4 b0", 4'b0010, 1'b0, 2'd0, 1'b0);
    cyc("t4 b1", 4'b0010, 1'b1, 2'd1, 1'b0);
    cyc("t4 b2", 4'b0010, 1'b1, 2'd1, 1'b1);
    cyc("t4 next", 4'b0100, 1'b0, 2'd0, 1'b1);
    cyc("t4 idle", 4'b0000, 1'b0, 2'd0, 1'b1);

    // Test 5: random backpressure, mixed scalar and a group.
    n0 = n_out;
    for (int k = 0; k < 3; k++) load(2, 2'd2, 4'd2, 4'd3);
    for (int k = 0; k < 24; k++) load(int'($urandom_range(0, N - 1)), 2'd0, 4'd0, 4'd0);
    rand_rdy = 1'b1;
    done     = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      done = (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() == 0)
             && (exp_q.size() == 0) && !out_valid;
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    chk("t5 drained", 32'(done), 1);
    chk("t5 beat count", 32'(n_out - n0), 27);
    @(negedge clk);
    chk("t5 seq_err sticky", 32'(seq_err), 1);
    tick();

    // Test 6: reset after beat 2 of a 4-beat group on req3.
    for (int k = 0; k < 4; k++) load(3, 2'd1, 4'd9, 4'd4);
    cyc("t6 b0", 4'b1000, 1'b0, 2'd0, 1'b1);
    load(0, 2'd0, 4'd0, 4'd0);
    load(1, 2'd0, 4'd0, 4'd0);
    cyc("t6 b1", 4'b1000, 1'b1, 2'd3, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t6 rst locked", 32'(locked), 0);
    chk("t6 rst out_valid", 32'(out_valid), 0);
    chk("t6 rst owner", 32'(lock_owner), 0);
    chk("t6 rst seq_err", 32'(seq_err), 0);
    exp_q.delete();
    src_q[3].delete();
    drive();
    @(posedge clk);
    #1 reset = 1'b1;
    cyc("t6 r0", 4'b0001, 1'b0, 2'd0, 1'b0);
    cyc("t6 r1", 4'b0010, 1'b0, 2'd0, 1'b0);
    cyc("t6 idle", 4'b0000, 1'b0, 2'd0, 1'b0);
    repeat (2) tick();
    chk("final scoreboard empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
